// File: rtl/saw_osc_gen.sv
// Sawtooth oscillator core: turns a cycles-per-step period word into a signed sawtooth
// sample stream, latching new periods only at the waveform wrap so note changes stay glitch-free.
module saw_osc_gen #(
    parameter int NBIT_PER = 16,
    parameter int NBIT_OUT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                gate,
    input  logic [NBIT_PER-1:0] period,
    output logic [NBIT_OUT-1:0] saw_out,
    output logic                step_strobe,
    output logic                active
);

    typedef enum logic [0:0] {
        ST_MUTE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [NBIT_PER-1:0] PER_ZERO = {NBIT_PER{1'b0}};
    localparam logic [NBIT_PER-1:0] PER_ONE  = {{(NBIT_PER-1){1'b0}}, 1'b1};
    localparam logic [NBIT_OUT-1:0] PH_ZERO  = {NBIT_OUT{1'b0}};
    localparam logic [NBIT_OUT-1:0] PH_ONE   = {{(NBIT_OUT-1){1'b0}}, 1'b1};

    // Offset-binary phase to two's-complement sample: flip the MSB.
    function automatic logic [NBIT_OUT-1:0] map_sample(input logic [NBIT_OUT-1:0] ph);
        return {~ph[NBIT_OUT-1], ph[NBIT_OUT-2:0]};
    endfunction

    state_t              state_r,    state_nxt_s;
    logic [NBIT_PER-1:0] per_act_r,  per_act_nxt_s;
    logic [NBIT_PER-1:0] per_cnt_r,  per_cnt_nxt_s;
    logic [NBIT_OUT-1:0] phase_r,    phase_nxt_s;
    logic [NBIT_OUT-1:0] saw_out_r,  saw_out_nxt_s;
    logic                strobe_r,   strobe_nxt_s;
    logic                active_r,   active_nxt_s;

    logic [NBIT_PER-1:0] per_last_s;
    logic [NBIT_OUT-1:0] phase_inc_s;
    logic                wrap_s;
    logic                period_ok_s;

    assign per_last_s  = per_act_r - PER_ONE;
    assign phase_inc_s = phase_r + PH_ONE;
    assign wrap_s      = &phase_r;
    assign period_ok_s = (period != PER_ZERO);

    // Next-state and next-output decode for one enabled clock.
    always_comb begin
        state_nxt_s   = state_r;
        per_act_nxt_s = per_act_r;
        per_cnt_nxt_s = per_cnt_r;
        phase_nxt_s   = phase_r;
        saw_out_nxt_s = saw_out_r;
        strobe_nxt_s  = 1'b0;
        active_nxt_s  = active_r;

        case (state_r)
            ST_MUTE: begin
                saw_out_nxt_s = PH_ZERO;
                active_nxt_s  = 1'b0;
                if (gate && period_ok_s) begin
                    state_nxt_s   = ST_RUN;
                    per_act_nxt_s = period;
                    per_cnt_nxt_s = PER_ZERO;
                    phase_nxt_s   = PH_ZERO;
                    saw_out_nxt_s = map_sample(PH_ZERO);
                    active_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s   = ST_MUTE;
                end
            end
            ST_RUN: begin
                if (!gate) begin
                    state_nxt_s   = ST_MUTE;
                    per_cnt_nxt_s = PER_ZERO;
                    phase_nxt_s   = PH_ZERO;
                    saw_out_nxt_s = PH_ZERO;
                    active_nxt_s  = 1'b0;
                end else if (per_cnt_r != per_last_s) begin
                    per_cnt_nxt_s = per_cnt_r + PER_ONE;
                end else if (wrap_s && !period_ok_s) begin
                    // Invalid note reached the wrap: mute instead of stepping.
                    state_nxt_s   = ST_MUTE;
                    per_cnt_nxt_s = PER_ZERO;
                    phase_nxt_s   = PH_ZERO;
                    saw_out_nxt_s = PH_ZERO;
                    active_nxt_s  = 1'b0;
                end else begin
                    per_cnt_nxt_s = PER_ZERO;
                    phase_nxt_s   = phase_inc_s;
                    saw_out_nxt_s = map_sample(phase_inc_s);
                    strobe_nxt_s  = 1'b1;
                    if (wrap_s) begin
                        per_act_nxt_s = period;
                    end else begin
                        per_act_nxt_s = per_act_r;
                    end
                end
            end
            default: begin
                state_nxt_s   = ST_MUTE;
                per_act_nxt_s = PER_ZERO;
                per_cnt_nxt_s = PER_ZERO;
                phase_nxt_s   = PH_ZERO;
                saw_out_nxt_s = PH_ZERO;
                active_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; a low enable freezes everything but kills the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_MUTE;
            per_act_r <= PER_ZERO;
            per_cnt_r <= PER_ZERO;
            phase_r   <= PH_ZERO;
            saw_out_r <= PH_ZERO;
            strobe_r  <= 1'b0;
            active_r  <= 1'b0;
        end else if (en) begin
            state_r   <= state_nxt_s;
            per_act_r <= per_act_nxt_s;
            per_cnt_r <= per_cnt_nxt_s;
            phase_r   <= phase_nxt_s;
            saw_out_r <= saw_out_nxt_s;
            strobe_r  <= strobe_nxt_s;
            active_r  <= active_nxt_s;
        end else begin
            strobe_r  <= 1'b0;
        end
    end

    assign saw_out     = saw_out_r;
    assign step_strobe = strobe_r;
    assign active      = active_r;

endmodule

// File: tb/tb_saw_osc_gen.sv
// Randomized and directed bench for saw_osc_gen, checked every cycle against a
// cycle-counting reference model of the oscillator's behaviour.
module tb_saw_osc_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic        gate;
    logic [15:0] period;
    logic [7:0]  saw_out;
    logic        step_strobe;
    logic        active;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: note playing?, latched period, enabled cycles since last step, phase.
    bit m_run;
    int m_per;
    int m_cnt;
    int m_phase;
    bit m_strb;

    saw_osc_gen #(.NBIT_PER(16), .NBIT_OUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .gate        (gate),
        .period      (period),
        .saw_out     (saw_out),
        .step_strobe (step_strobe),
        .active      (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_per = 0; m_cnt = 0; m_phase = 0; m_strb = 1'b0;
    endtask

    task automatic model_edge();
        m_strb = 1'b0;
        if (en) begin
            if (!m_run) begin
                if (gate && period != 16'd0) begin
                    m_run = 1'b1; m_per = int'(period); m_cnt = 0; m_phase = 0;
                end
            end else if (!gate) begin
                m_run = 1'b0; m_phase = 0;
            end else begin
                m_cnt++;
                if (m_cnt == m_per) begin
                    m_cnt = 0;
                    if (m_phase == 255) begin
                        if (period == 16'd0) begin
                            m_run = 1'b0; m_phase = 0;
                        end else begin
                            m_per = int'(period); m_phase = 0; m_strb = 1'b1;
                        end
                    end else begin
                        m_phase++; m_strb = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] exp_saw;
        exp_saw = m_run ? (8'(m_phase) ^ 8'h80) : 8'h00;
        check_val({tag, ".saw"},    32'(saw_out),     32'(exp_saw));
        check_val({tag, ".strobe"}, 32'(step_strobe), 32'(m_strb));
        check_val({tag, ".active"}, 32'(active),      32'(m_run));
    endtask

    // Inputs are applied at the negedge, the model follows the posedge, outputs checked at next negedge.
    task automatic cycle(input string tag, input bit g, input logic [15:0] p, input bit e);
        gate = g; period = p; en = e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        int strobes;
        rst = 1'b1; en = 1'b0; gate = 1'b0; period = 16'd0;
        model_reset();
        #2;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic run, period 3: full waveform of 768 cycles plus margin.
        cycle("start", 1'b1, 16'd3, 1'b1);
        check_val("start.saw80", 32'(saw_out), 32'h80);
        strobes = 0;
        for (int i = 0; i < 780; i++) begin
            cycle("basic", 1'b1, 16'd3, 1'b1);
            if (step_strobe) strobes++;
        end
        check_val("basic.nstrobe", 32'(strobes), 32'd260);

        // Async reset mid-run with per_act=3.
        cycle("prerst", 1'b1, 16'd3, 1'b1);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) cycle("mute_p0", 1'b1, 16'd0, 1'b1);

        // Deferred period change 3 -> 5 at phase 0x10.
        cycle("restart", 1'b1, 16'd3, 1'b1);
        for (int i = 0; i < 100 && m_phase != 16; i++) cycle("to10", 1'b1, 16'd3, 1'b1);
        check_val("reach10", 32'(m_phase), 32'd16);
        for (int i = 0; i < 720 + 5 * 40; i++) cycle("defer", 1'b1, 16'd5, 1'b1);

        // Period goes invalid mid-run: keep running until the wrap, then mute.
        for (int i = 0; i < 5 * 256 + 10; i++) cycle("p0run", 1'b1, 16'd0, 1'b1);
        check_val("p0.muted", 32'(active), 32'd0);

        // per_act=1 and gate drop at phase 0x05.
        cycle("p1start", 1'b1, 16'd1, 1'b1);
        for (int i = 0; i < 5; i++) cycle("p1run", 1'b1, 16'd1, 1'b1);
        check_val("p1.saw85", 32'(saw_out), 32'h85);
        cycle("gateoff", 1'b0, 16'd1, 1'b1);
        check_val("gateoff.saw", 32'(saw_out), 32'h00);

        // Enable freeze for 10 cycles mid-step.
        cycle("enstart", 1'b1, 16'd4, 1'b1);
        cycle("enrun", 1'b1, 16'd4, 1'b1);
        for (int i = 0; i < 10; i++) cycle("freeze", 1'b1, 16'd4, 1'b0);
        for (int i = 0; i < 40; i++) cycle("unfreeze", 1'b1, 16'd4, 1'b1);

        // Random stimulus.
        for (int i = 0; i < 6000; i++) begin
            bit g, e;
            logic [15:0] p;
            g = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 9) != 0);
            p = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 4));
            cycle("rand", g, p, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
